mcu_core_p: RTL and testbench

MCU_CORE_P -- requirements
Module: mcu_core_p

---
 rtl/mcu_core_pkg.sv | 20 ++
 rtl/mcu_alu.sv | 57 +++++
 rtl/mcu_core_p.sv | 95 +++++++++
 tb/tb_mcu_core_p.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mcu_core_pkg.sv
// mcu_core_pkg: FSM state encoding and opcode map shared by the core and its ALU
package mcu_core_pkg;
    typedef enum logic [2:0] {IF = 3'd0, FD = 3'd1, EX = 3'd2, RWB = 3'd3, HALT = 3'd4} state_t;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_ADI  = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_COMP = 4'hC;
    localparam logic [3:0] OP_CMPJ = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;
endpackage

// File: rtl/mcu_alu.sv
// mcu_alu: combinational ALU with carry/overflow flags; MCU_CORE_MULDIV_EN adds MUL and DIV
module mcu_alu
    import mcu_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    ra,
    input  logic [3:0]    rb,
    output logic [DW-1:0] result,
    output logic          cout,
    output logic          of
);
    logic [DW-1:0] imm;
    assign imm = DW'(rb);
    always_comb begin
        result = '0;
        cout   = 1'b0;
        of     = 1'b0;
        case (op)
            OP_ADD: begin
                {cout, result} = {1'b0, a} + {1'b0, b};
                of = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            OP_LDI: result = DW'({ra, rb});
            OP_SUB: begin
                result = a - b;
                cout   = a >= b;
                of     = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            OP_ADI: begin
                {cout, result} = {1'b0, a} + {1'b0, imm};
                of = (a[DW-1] == imm[DW-1]) && (result[DW-1] != a[DW-1]);
            end
`ifdef MCU_CORE_MULDIV_EN
            OP_MUL: result = a * b;
            OP_DIV: result = (b == '0) ? '1 : a / b;
`endif
            OP_DEC: begin
                result = b - DW'(1);
                cout   = |b;
                of     = b[DW-1] & ~result[DW-1];
            end
            OP_INC: begin
                {cout, result} = {1'b0, b} + (DW+1)'(1);
                of = ~b[DW-1] & result[DW-1];
            end
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XOR:  result = a ^ b;
            OP_COMP: result = ~b;
            default: ;
        endcase
    end
endmodule

// File: rtl/mcu_core_p.sv
// mcu_core_p: four-cycle multicycle core (IF/FD/EX/RWB) with 16-entry register file
// and HALT; MCU_CORE_MULDIV_EN enables the MUL/DIV opcodes in mcu_alu.
module mcu_core_p
    import mcu_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [PW-1:0] imem_addr,
    input  logic [15:0]   imem_data,
    output logic [PW-1:0] pc,
    output logic [2:0]    state,
    output logic [3:0]    opcode,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] w_reg,
    output logic          cout,
    output logic          of,
    output logic          halted
);
    state_t        st, nxt;
    logic [15:0]   ir;
    logic [DW-1:0] a, b;
    logic [DW-1:0] rf [16];
    logic [3:0]    ra, rb, rd;
    logic          alu_c, alu_o, rf_we;
    logic [PW-1:0] pc_nxt;

    assign opcode = ir[15:12];
    assign ra     = ir[11:8];
    assign rb     = ir[7:4];
    assign rd     = ir[3:0];

    mcu_alu #(.DW(DW)) u_alu (
        .op(opcode), .a(a), .b(b), .ra(ra), .rb(rb),
        .result(alu_out), .cout(alu_c), .of(alu_o)
    );

    always_ff @(posedge clk) begin
        if (reset) st <= IF;
        else       st <= nxt;
    end

    always_comb begin
        nxt = (st == IF)  ? (run ? FD : IF) :
              (st == FD)  ? EX :
              (st == EX)  ? RWB :
              (st == RWB) ? ((opcode == OP_HLT) ? HALT : IF) : HALT;
    end

    always_comb begin
        state     = st;
        halted    = (st == HALT);
        imem_addr = pc;
    end

    // Only opcodes 1..C write back; control-flow opcodes and NOP leave the RF alone.
    assign rf_we  = (opcode != OP_NOP) && (opcode < OP_CMPJ);
    assign pc_nxt = (opcode == OP_CMPJ) ? ((a >= b) ? pc + PW'(rd) : pc + PW'(1)) :
                    (opcode == OP_JMP)  ? PW'({ra, rb}) :
                    (opcode == OP_HLT)  ? pc : pc + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            w_reg <= '0;
            cout  <= 1'b0;
            of    <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (st)
                IF: if (run) ir <= imem_data;
                FD: begin
                    a <= rf[ra];
                    b <= rf[rb];
                end
                EX: begin
                    w_reg <= alu_out;
                    cout  <= alu_c;
                    of    <= alu_o;
                end
                RWB: begin
                    if (rf_we) rf[rd] <= w_reg;
                    pc <= pc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_core_p.sv
// tb_mcu_core_p: directed program checks for mcu_core_p (DW=8, PW=8)
module tb_mcu_core_p;
    logic        clk, reset, run;
    logic [7:0]  imem_addr, pc, alu_out, w_reg;
    logic [15:0] imem_data;
    logic [2:0]  state;
    logic [3:0]  opcode;
    logic        cout, of, halted;
    logic [15:0] imem [256];
    int          errors = 0;
    int          checks = 0;

    mcu_core_p #(.DW(8), .PW(8)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .state(state), .opcode(opcode), .alu_out(alu_out), .w_reg(w_reg),
        .cout(cout), .of(of), .halted(halted)
    );

    assign imem_data = imem[imem_addr];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 0;
        reset = 1;
        tick(1);
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        reset = 0;
        run = 0;
        imem[0] = 16'h2A53;
        imem[1] = 16'h27F0;
        imem[2] = 16'h2011;
        imem[3] = 16'h1012;
        imem[4] = 16'h3012;
        imem[5] = 16'h3102;
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_state", state, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wreg", w_reg, 0);
        chk("rst_flags", {cout, of}, 0);
        chk("rst_rf3", dut.rf[3], 0);
        run = 1;
        tick(1);
        chk("ldi_fd", state, 1);
        tick(3);
        chk("ldi_rf3", dut.rf[3], 8'hA5);
        chk("ldi_pc", pc, 1);
        chk("ldi_state", state, 0);
        tick(12);
        chk("add_pc", pc, 4);
        chk("add_wreg", w_reg, 8'h80);
        chk("add_cout", cout, 0);
        chk("add_of", of, 1);
        chk("add_rf2", dut.rf[2], 8'h80);
        tick(4);
        chk("sub1_wreg", w_reg, 8'h7E);
        chk("sub1_flags", {cout, of}, 2'b10);
        tick(4);
        chk("sub2_wreg", w_reg, 8'h82);
        chk("sub2_flags", {cout, of}, 2'b00);

        do_reset();
        imem[0] = 16'h2052;
        imem[1] = 16'h2033;
        imem[2] = 16'h0000;
        imem[3] = 16'h0000;
        imem[4] = 16'hD236;
        run = 1;
        tick(20);
        chk("cmpj_taken_pc", pc, 8'h0A);
        chk("cmpj_no_wr", dut.rf[6], 0);
        do_reset();
        imem[0] = 16'h2022;
        run = 1;
        tick(20);
        chk("cmpj_not_pc", pc, 8'h05);

        run = 0;
        imem[5] = 16'h2127;
        imem[6] = 16'h2348;
        imem[7] = 16'hF000;
        tick(10);
        chk("stall_state", state, 0);
        chk("stall_pc", pc, 8'h05);
        run = 1;
        tick(4);
        chk("resume_pc", pc, 8'h06);
        chk("resume_state", state, 0);
        chk("resume_rf7", dut.rf[7], 8'h12);
        tick(1);
        run = 0;
        tick(3);
        chk("midrun_pc", pc, 8'h07);
        chk("midrun_rf8", dut.rf[8], 8'h34);

        run = 1;
        tick(3);
        chk("hlt_rwb", state, 3);
        tick(1);
        chk("hlt_state", state, 4);
        chk("hlt_halted", halted, 1);
        tick(20);
        chk("hlt_pc_held", pc, 8'h07);
        chk("hlt_state_held", state, 4);
        chk("hlt_rf8_held", dut.rf[8], 8'h34);
        reset = 1;
        tick(1);
        chk("hrst_pc", pc, 0);
        chk("hrst_state", state, 0);
        chk("hrst_halted", halted, 0);
        chk("hrst_rf8", dut.rf[8], 0);

        do_reset();
        imem[0] = 16'h2094;
        imem[1] = 16'h2005;
        imem[2] = 16'h6456;
        imem[3] = 16'h2025;
        imem[4] = 16'h6456;
        imem[5] = 16'h5457;
        run = 1;
        tick(12);
`ifdef MCU_CORE_MULDIV_EN
        chk("div0_rf6", dut.rf[6], 8'hFF);
`else
        chk("div0_rf6", dut.rf[6], 8'h00);
`endif
        chk("div0_flags", {cout, of}, 0);
        tick(8);
`ifdef MCU_CORE_MULDIV_EN
        chk("div2_rf6", dut.rf[6], 8'h04);
`else
        chk("div2_rf6", dut.rf[6], 8'h00);
`endif
        tick(4);
`ifdef MCU_CORE_MULDIV_EN
        chk("mul_rf7", dut.rf[7], 8'h12);
`else
        chk("mul_rf7", dut.rf[7], 8'h00);
`endif
        chk("mul_pc", pc, 8'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
